// File: rtl/simple_uart_fifo_mem.sv
// ---------------------------------------------------------------------------
// simple_uart_fifo_mem
//
// Purpose:
//   Generic register-array storage for small FIFOs. It has one synchronous
//   write port and one asynchronous read port. The FIFO control logic (pointers,
//   count, flags) lives in the instantiating module, so the same storage can
//   back either a TX-side or an RX-side FIFO.
//
// Parameters:
//   DEPTH_LOG2  log2 of the number of entries
//   WIDTH       bits per entry
//
// Ports:
//   clock_i     rising-edge clock for the write port
//   wr_en_i     write strobe; wr_data_i is stored at wr_addr_i on the edge
//   wr_addr_i   write address
//   wr_data_i   write data
//   rd_addr_i   read address (combinational read)
//   rd_data_o   entry currently stored at rd_addr_i
// ---------------------------------------------------------------------------
module simple_uart_fifo_mem #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 8
) (
  input  logic                  clock_i,
  input  logic                  wr_en_i,
  input  logic [DEPTH_LOG2-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]      wr_data_i,
  input  logic [DEPTH_LOG2-1:0] rd_addr_i,
  output logic [WIDTH-1:0]      rd_data_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0] mem_q [DEPTH];

  // The storage is not reset. An entry is only read after the control
  // logic has written it, so clearing it would add reset fan-out without
  // changing any behaviour.
  always_ff @(posedge clock_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // The read is asynchronous so that the head entry is available in the same
  // cycle the control logic decides to pop it.
  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/simple_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// simple_uart_tx_fifo
//
// Purpose:
//   Byte FIFO placed in front of the simple_uart transmitter. Producers push
//   bursts of bytes at full clock rate. The FIFO hands them to the UART one at a
//   time through the tx_value / tx_value_write / tx_value_done handshake,
//   with exactly one byte in flight at any time.
//
// Parameters:
//   DEPTH_LOG2      log2 of the FIFO depth (1..10)
//
// Ports:
//   clock           system clock, rising edge
//   arst            asynchronous active-high reset
//   wr_data         byte to enqueue
//   wr_en           push request; accepted when not full
//   flush           synchronous clear of stored entries (byte in flight kept)
//   full            stored entry count equals the depth
//   empty           no stored entries
//   count           number of stored entries, excluding the byte in flight
//   busy            a byte is with the UART and not yet acknowledged
//   tx_value        byte presented to the UART, stable until done
//   tx_value_write  one-cycle registered write strobe to the UART
//   tx_value_done   one-cycle completion pulse from the UART
//   overflow        sticky dropped-push flag (only with the macro below)
//
// Configuration:
//   SIMPLE_UART_TX_FIFO_OVERFLOW_EN  when defined, adds the overflow output.
// ---------------------------------------------------------------------------
module simple_uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clock,
  input  logic                  arst,
  input  logic [7:0]            wr_data,
  input  logic                  wr_en,
  input  logic                  flush,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  busy,
  output logic [7:0]            tx_value,
  output logic                  tx_value_write,
  input  logic                  tx_value_done
`ifdef SIMPLE_UART_TX_FIFO_OVERFLOW_EN
  ,
  output logic                  overflow
`endif
);

  localparam int   DEPTH    = 1 << DEPTH_LOG2;
  localparam int   CNT_W    = DEPTH_LOG2 + 1;
  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_BUSY  = 1'b1;

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  state_q, state_d;
  logic [7:0]            tx_value_q, tx_value_d;
  logic                  tx_write_q, tx_write_d;
  logic [7:0]            head_data;
  logic                  push_en;
  logic                  pop_en;

  // Flags decode the registered count, so they describe the FIFO as it
  // stands before the coming edge. A push that meets a same-cycle pop on a
  // full FIFO is therefore still refused.
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // flush wins over both directions. A pop is only issued from IDLE, which
  // keeps a single byte in flight.
  assign push_en = wr_en && !full && !flush;
  assign pop_en  = (state_q == ST_IDLE) && !empty && !flush;

  simple_uart_fifo_mem #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (8)
  ) u_mem (
    .clock_i    (clock),
    .wr_en_i    (push_en),
    .wr_addr_i  (wr_ptr_q),
    .wr_data_i  (wr_data),
    .rd_addr_i  (rd_ptr_q),
    .rd_data_o  (head_data)
  );

  // Pointer and count bookkeeping. The pointers wrap naturally at DEPTH.
  // When a push and a pop occur together, the count stays the same.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) begin
        wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
      end
      if (pop_en) begin
        rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
      end
      case ({push_en, pop_en})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Hand-off state machine. In IDLE, the head byte is latched into tx_value
  // and a single-cycle strobe is raised. In BUSY, the machine waits for the
  // UART's done pulse. flush does not touch this path, so a byte already
  // handed over always completes.
  always_comb begin
    state_d    = state_q;
    tx_value_d = tx_value_q;
    tx_write_d = 1'b0;
    if (state_q == ST_IDLE) begin
      if (pop_en) begin
        tx_value_d = head_data;
        tx_write_d = 1'b1;
        state_d    = ST_BUSY;
      end
    end else begin
      if (tx_value_done) begin
        state_d = ST_IDLE;
      end
    end
  end

  // All control state is cleared immediately on arst. The UART is reset
  // separately, so no done pulse is awaited for an abandoned byte.
  always_ff @(posedge clock or posedge arst) begin
    if (arst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= ST_IDLE;
      tx_value_q <= 8'h00;
      tx_write_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      tx_value_q <= tx_value_d;
      tx_write_q <= tx_write_d;
    end
  end

  assign count          = count_q;
  assign busy           = (state_q == ST_BUSY);
  assign tx_value       = tx_value_q;
  assign tx_value_write = tx_write_q;

`ifdef SIMPLE_UART_TX_FIFO_OVERFLOW_EN
  logic overflow_q, overflow_d;

  // Sticky record of any refused push. flush clears it even when a refused
  // push arrives on the same edge.
  always_comb begin
    overflow_d = overflow_q;
    if (flush) begin
      overflow_d = 1'b0;
    end else if (wr_en && full) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge arst) begin
    if (arst) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign overflow = overflow_q;
`else
  // Without the flag, a push to a full FIFO is simply refused by push_en.
`endif

endmodule

// File: tb/tb_simple_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// tb_simple_uart_tx_fifo
//
// Purpose:
//   Self-checking bench for simple_uart_tx_fifo. A queue-based reference model
//   tracks the stored bytes, the byte in flight and the strobe. A small UART
//   stand-in answers each write strobe with a done pulse after a random
//   delay. Directed sequences are followed by a randomized traffic phase.
// ---------------------------------------------------------------------------
module tb_simple_uart_tx_fifo;

  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  logic                clock = 1'b0;
  logic                arst  = 1'b0;
  logic [7:0]          wr_data = 8'h00;
  logic                wr_en = 1'b0;
  logic                flush = 1'b0;
  logic                full;
  logic                empty;
  logic [DEPTH_LOG2:0] count;
  logic                busy;
  logic [7:0]          tx_value;
  logic                tx_value_write;
  logic                tx_value_done = 1'b0;
`ifdef SIMPLE_UART_TX_FIFO_OVERFLOW_EN
  logic                overflow;
`endif

  simple_uart_tx_fifo #(
    .DEPTH_LOG2     (DEPTH_LOG2)
  ) dut (
    .clock          (clock),
    .arst           (arst),
    .wr_data        (wr_data),
    .wr_en          (wr_en),
    .flush          (flush),
    .full           (full),
    .empty          (empty),
    .count          (count),
    .busy           (busy),
    .tx_value       (tx_value),
    .tx_value_write (tx_value_write),
    .tx_value_done  (tx_value_done)
`ifdef SIMPLE_UART_TX_FIFO_OVERFLOW_EN
    ,
    .overflow       (overflow)
`endif
  );

  always #5 clock = ~clock;

  int checksTotal  = 0;
  int checksPassed = 0;

  // Reference model state
  byte unsigned mQ[$];
  bit           mBusy   = 1'b0;
  bit           mStrobe = 1'b0;
  bit           mOvf    = 1'b0;
  logic [7:0]   mTxv    = 8'h00;

  // Bytes the model says must leave, and bytes seen leaving the DUT
  byte unsigned expSent[$];
  byte unsigned gotSent[$];

  bit uartHold = 1'b0;

  task automatic checkOutput(input string name, input int unsigned actual,
                             input int unsigned expected);
    checksTotal++;
    if (actual == expected) begin
      checksPassed++;
    end else begin
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present one cycle of producer inputs, then return them to idle
  task automatic applyStimulus(input bit we, input logic [7:0] d, input bit fl);
    wr_en   = we;
    wr_data = d;
    flush   = fl;
    tick();
    wr_en = 1'b0;
    flush = 1'b0;
  endtask

  task automatic waitIdle(input int maxCycles);
    for (int i = 0; i < maxCycles && (mBusy || mQ.size() != 0); i++) begin
      tick();
    end
    checkOutput("drain busy", busy, 0);
    checkOutput("drain empty", empty, 1);
  endtask

  // Behavioural model: a byte queue, plus one slot for the byte with the UART.
  // On each edge the slot is refilled from the queue head if it was free.
  initial begin
    bit wasFull;
    bit doPop;
    forever begin
      @(posedge clock or posedge arst);
      if (arst) begin
        mQ.delete();
        mBusy   = 1'b0;
        mStrobe = 1'b0;
        mOvf    = 1'b0;
        mTxv    = 8'h00;
      end else begin
        wasFull = (mQ.size() == DEPTH);
        doPop   = !mBusy && (mQ.size() != 0) && !flush;
        mStrobe = 1'b0;
        if (mBusy) begin
          if (tx_value_done) mBusy = 1'b0;
        end else if (doPop) begin
          mTxv    = mQ.pop_front();
          mStrobe = 1'b1;
          mBusy   = 1'b1;
          expSent.push_back(mTxv);
        end
        if (flush) begin
          mQ.delete();
          mOvf = 1'b0;
        end else if (wr_en) begin
          if (wasFull) mOvf = 1'b1;
          else         mQ.push_back(wr_data);
        end
      end
    end
  end

  // UART stand-in: acknowledges each strobe with a one-cycle done pulse a
  // random number of cycles later, unless it is being stalled.
  initial begin
    int timer;
    timer = 0;
    forever begin
      tick();
      if (tx_value_done) begin
        tx_value_done = 1'b0;
      end else if (mStrobe) begin
        timer = $urandom_range(2, 12);
      end else if (mBusy && !uartHold) begin
        if (timer > 0) timer--;
        if (timer == 0) tx_value_done = 1'b1;
      end
    end
  end

  // Compare DUT outputs against the model on every falling edge
  always @(negedge clock) begin
    checkOutput("count", count, mQ.size());
    checkOutput("full", full, (mQ.size() == DEPTH));
    checkOutput("empty", empty, (mQ.size() == 0));
    checkOutput("busy", busy, mBusy);
    checkOutput("tx_value", tx_value, mTxv);
    checkOutput("tx_value_write", tx_value_write, mStrobe);
`ifdef SIMPLE_UART_TX_FIFO_OVERFLOW_EN
    checkOutput("overflow", overflow, mOvf);
`endif
    if (tx_value_write) gotSent.push_back(tx_value);
  end

  initial begin
    int sentBefore;

    // Reset state
    #2 arst = 1'b1;
    repeat (3) tick();
    checkOutput("reset count", count, 0);
    checkOutput("reset empty", empty, 1);
    checkOutput("reset full", full, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset tx_value", tx_value, 8'h00);
    checkOutput("reset strobe", tx_value_write, 0);
    arst = 1'b0;
    tick();

    // Single push: strobe exactly one cycle after the push edge
    applyStimulus(1'b1, 8'h55, 1'b0);
    checkOutput("t1 count after push", count, 1);
    checkOutput("t1 no bypass strobe", tx_value_write, 0);
    tick();
    checkOutput("t1 strobe", tx_value_write, 1);
    checkOutput("t1 tx_value", tx_value, 8'h55);
    checkOutput("t1 busy", busy, 1);
    checkOutput("t1 count after pop", count, 0);
    tick();
    checkOutput("t1 strobe low", tx_value_write, 0);
    checkOutput("t1 still busy", busy, 1);
    waitIdle(200);

    // Burst into a stalled UART, then overflow
    uartHold   = 1'b1;
    sentBefore = gotSent.size();
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'(i), 1'b0);
    checkOutput("t2 count after burst", count, 15);
    checkOutput("t2 full after burst", full, 0);
    applyStimulus(1'b1, 8'h10, 1'b0);
    checkOutput("t3 count at full", count, 16);
    checkOutput("t3 full", full, 1);
    applyStimulus(1'b1, 8'hEE, 1'b0);
    checkOutput("t3 count after drop", count, 16);
`ifdef SIMPLE_UART_TX_FIFO_OVERFLOW_EN
    checkOutput("t3 overflow set", overflow, 1);
`endif
    uartHold = 1'b0;
    waitIdle(1000);
    checkOutput("t3 sent bytes", gotSent.size() - sentBefore, 17);
    for (int i = 0; i < 17; i++) begin
      checkOutput("t3 order", gotSent[sentBefore + i], i);
    end

    // Flush while a byte is in flight
    uartHold   = 1'b1;
    sentBefore = gotSent.size();
    applyStimulus(1'b1, 8'hAA, 1'b0);
    applyStimulus(1'b1, 8'hBB, 1'b0);
    applyStimulus(1'b1, 8'hCC, 1'b0);
    checkOutput("t5 count before flush", count, 2);
    checkOutput("t5 busy before flush", busy, 1);
`ifdef SIMPLE_UART_TX_FIFO_OVERFLOW_EN
    checkOutput("t5 overflow before flush", overflow, 1);
`endif
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("t5 count after flush", count, 0);
    checkOutput("t5 busy after flush", busy, 1);
    checkOutput("t5 tx_value kept", tx_value, 8'hAA);
`ifdef SIMPLE_UART_TX_FIFO_OVERFLOW_EN
    checkOutput("t5 overflow cleared", overflow, 0);
`endif
    uartHold = 1'b0;
    waitIdle(200);
    checkOutput("t5 sent bytes", gotSent.size() - sentBefore, 1);
    checkOutput("t5 sent value", gotSent[gotSent.size() - 1], 8'hAA);

    // Wrap-around: paced pushes, slower than the UART drains them
    sentBefore = gotSent.size();
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b1, 8'hA0 + 8'(i), 1'b0);
      repeat ($urandom_range(14, 25)) tick();
    end
    waitIdle(200);
    checkOutput("t4 sent bytes", gotSent.size() - sentBefore, 40);
    for (int i = 0; i < 40 && sentBefore + i < gotSent.size(); i++) begin
      checkOutput("t4 order", gotSent[sentBefore + i], (8'hA0 + i) & 8'hFF);
    end

    // Asynchronous reset mid-byte
    uartHold = 1'b1;
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'h61 + 8'(i), 1'b0);
    checkOutput("t6 count before reset", count, 5);
    checkOutput("t6 busy before reset", busy, 1);
    @(posedge clock);
    #2 arst = 1'b1;
    #1;
    checkOutput("t6 full", full, 0);
    checkOutput("t6 empty", empty, 1);
    checkOutput("t6 count", count, 0);
    checkOutput("t6 busy", busy, 0);
    checkOutput("t6 strobe", tx_value_write, 0);
    checkOutput("t6 tx_value", tx_value, 8'h00);
    tick();
    arst     = 1'b0;
    uartHold = 1'b0;
    tick();
    sentBefore = gotSent.size();
    applyStimulus(1'b1, 8'h3C, 1'b0);
    waitIdle(200);
    checkOutput("t6 sent bytes", gotSent.size() - sentBefore, 1);
    checkOutput("t6 sent value", gotSent[gotSent.size() - 1], 8'h3C);

    // Randomized traffic with stalls and occasional flushes
    for (int c = 0; c < 3000; c++) begin
      wr_en    = ($urandom_range(0, 99) < ((c < 1500) ? 70 : 20));
      wr_data  = 8'($urandom);
      flush    = ($urandom_range(0, 199) == 0);
      uartHold = ((c % 600) < 100);
      tick();
    end
    wr_en    = 1'b0;
    flush    = 1'b0;
    uartHold = 1'b0;
    waitIdle(1000);

    // Every byte the model released must have appeared, in order
    checkOutput("total sent", gotSent.size(), expSent.size());
    for (int i = 0; i < gotSent.size() && i < expSent.size(); i++) begin
      checkOutput("sent byte", gotSent[i], expSent[i]);
    end

    $display("[TB] %0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
